lcg_sample_loader: RTL

Front end of the LCG seed-recovery path, directly upstream of the seed scanner. Receives a framed byte stream carrying three consecutive observed RNG outputs, checks the frame, and presents them as `expected_v0..v2` to the scanner. It emits a one-cycle `start` pulse whenever a fresh, verified sample set is loaded. Outputs change only on a fully verified frame, so the scanner never sees a torn or partially updated value set.

---
 rtl/lcg_sample_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lcg_sample_loader.sv
// Deframes SYNC + 3*BPW payload + XOR checksum into three verified sample words.
// Latency: outputs and pulses update one cycle after the checksum byte; no backpressure.
module lcg_sample_loader #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 16000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] expected_v0,
  output logic [WIDTH-1:0] expected_v1,
  output logic [WIDTH-1:0] expected_v2,
  output logic             valid,
  output logic             start,
  output logic             err_checksum,
  output logic             err_timeout
);

  localparam int unsigned BPW    = WIDTH / 8;
  localparam int unsigned NBYTES = 3 * BPW;
  localparam int unsigned IDXW   = $clog2(NBYTES);
  localparam int unsigned TMOW   = $clog2(TIMEOUT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t                 state, state_nxt;
  logic [IDXW-1:0]        idx;
  logic [7:0]             csum;
  logic [TMOW-1:0]        tmo_cnt;
  logic [NBYTES-1:0][7:0] shadow;

  logic accept;
  logic sync_hit;
  logic pay_wr;
  logic load;
  logic cs_bad;
  logic tmo_fire;

  // clear drops any byte presented in the same cycle
  assign accept = rx_valid && !clear;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sync_hit  = 1'b0;
    pay_wr    = 1'b0;
    load      = 1'b0;
    cs_bad    = 1'b0;
    tmo_fire  = 1'b0;
    unique case (state)
      HUNT: begin
        if (accept && rx_data == SYNC) begin
          sync_hit  = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          pay_wr = 1'b1;
          if (idx == LAST_IDX) state_nxt = CHECK;
        end else if (!clear && tmo_cnt == TMO_LAST) begin
          tmo_fire  = 1'b1;
          state_nxt = HUNT;
        end
      end
      CHECK: begin
        if (accept) begin
          state_nxt = HUNT;
          if (rx_data == csum) load   = 1'b1;
          else                 cs_bad = 1'b1;
        end else if (!clear && tmo_cnt == TMO_LAST) begin
          tmo_fire  = 1'b1;
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (clear) state_nxt = HUNT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx          <= '0;
      csum         <= '0;
      tmo_cnt      <= '0;
      shadow       <= '0;
      expected_v0  <= '0;
      expected_v1  <= '0;
      expected_v2  <= '0;
      valid        <= 1'b0;
      start        <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      start        <= load;
      err_checksum <= cs_bad;
      err_timeout  <= tmo_fire;

      if (clear || sync_hit) begin
        idx  <= '0;
        csum <= '0;
      end else if (pay_wr) begin
        idx  <= idx + 1'b1;
        csum <= csum ^ rx_data;
      end

      if (pay_wr) shadow[idx] <= rx_data;

      // counter idles at zero in HUNT so entry to PAYLOAD starts from zero
      if (clear || accept || tmo_fire || state == HUNT) tmo_cnt <= '0;
      else                                              tmo_cnt <= tmo_cnt + 1'b1;

      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid       <= 1'b1;
        expected_v0 <= shadow[BPW-1:0];
        expected_v1 <= shadow[2*BPW-1:BPW];
        expected_v2 <= shadow[3*BPW-1:2*BPW];
      end
    end
  end

endmodule
